operand_alu_seq: RTL and testbench

Sequential, handshaked arithmetic stage that consumes operand pairs plus an opcode from an upstream valid/ready source. It produces one registered result per transaction to a downstream valid/ready sink. Most ops complete in one cycle. Power (a**b) is computed iteratively by square-and-multiply with fixed latency. The block sits directly downstream of the operand-generation logic and feeds the result-collection stage.

---
 rtl/operand_alu_seq.sv | 147 ++++++++++++++
 tb/tb_operand_alu_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/operand_alu_seq.sv
// Handshaked arithmetic stage: single-cycle ALU ops plus an iterative
// square-and-multiply POW with fixed EXP_WIDTH-cycle latency.
module operand_alu_seq #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned EXP_WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_flag,
    output logic             busy
);

    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(EXP_WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_DIV = 3'd6;
    localparam logic [2:0] OP_POW = 3'd7;

    typedef enum logic {
        IDLE,
        ITER
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exp_bits;
    logic [CNT_W-1:0]     cnt;

    logic                 accept;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH-1:0]     alu_result;
    logic                 alu_flag;
    logic [WIDTH-1:0]     acc_mul;
    logic [WIDTH-1:0]     base_sq;
    logic [WIDTH-1:0]     acc_step;

    // Accept only when idle and the output register is empty or draining.
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign sum_ext  = {1'b0, in_a} + {1'b0, in_b};

    // Products wrap at WIDTH bits by construction.
    assign acc_mul  = acc * base;
    assign base_sq  = base * base;
    assign acc_step = exp_bits[0] ? acc_mul : acc;

    // Single-cycle operation datapath.
    always_comb begin
        alu_result = '0;
        alu_flag   = 1'b0;
        case (in_op)
            OP_ADD: begin
                alu_result = sum_ext[WIDTH-1:0];
                alu_flag   = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_result = in_a - in_b;
                alu_flag   = (in_a < in_b);
            end
            OP_AND: alu_result = in_a & in_b;
            OP_OR:  alu_result = in_a | in_b;
            OP_XOR: alu_result = in_a ^ in_b;
            OP_SLL: alu_result = in_a << in_b[SH_W-1:0];
            OP_DIV: begin
                if (in_b == '0) begin
                    alu_result = '0;
                    alu_flag   = 1'b1;
                end else begin
                    alu_result = in_a / in_b;
                end
            end
            default: begin
                alu_result = '0;
                alu_flag   = 1'b0;
            end
        endcase
    end

    // Control, output register and POW iteration state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flag   <= 1'b0;
            busy       <= 1'b0;
            acc        <= '0;
            base       <= '0;
            exp_bits   <= '0;
            cnt        <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_op == OP_POW) begin
                            state    <= ITER;
                            acc      <= WIDTH'(1);
                            base     <= in_a;
                            exp_bits <= in_b[EXP_WIDTH-1:0];
                            cnt      <= CNT_W'(EXP_WIDTH);
                            busy     <= 1'b1;
                        end else begin
                            out_result <= alu_result;
                            out_flag   <= alu_flag;
                            out_valid  <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    acc      <= acc_step;
                    base     <= base_sq;
                    exp_bits <= exp_bits >> 1;
                    cnt      <= cnt - CNT_W'(1);
                    // Fixed iteration count: no early exit on a zero exponent.
                    if (cnt == CNT_W'(1)) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        out_result <= acc_step;
                        out_flag   <= 1'b0;
                        out_valid  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_alu_seq.sv
// Directed bench for operand_alu_seq: vector table for single-cycle ops,
// hand-written sequences for POW timing, backpressure and reset abort.
module tb_operand_alu_seq;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_flag;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    operand_alu_seq #(.WIDTH(16), .EXP_WIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_flag  (out_flag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        flag;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // POW accepted at edge N; result must appear only after edge N+5.
    task automatic pow_check(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp_res);
        in_valid = 1'b1; in_op = 3'd7; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0; in_op = 3'd0; in_a = 16'hDEAD; in_b = 16'h0003;
        check($sformatf("pow%0d_%0d busy@N", a, b), 32'(busy), 32'd1);
        check($sformatf("pow%0d_%0d ready@N", a, b), 32'(in_ready), 32'd0);
        check($sformatf("pow%0d_%0d valid@N", a, b), 32'(out_valid), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check($sformatf("pow%0d_%0d busy@N+%0d", a, b, k), 32'(busy), 32'd1);
            check($sformatf("pow%0d_%0d ready@N+%0d", a, b, k), 32'(in_ready), 32'd0);
            check($sformatf("pow%0d_%0d valid@N+%0d", a, b, k), 32'(out_valid), 32'd0);
        end
        tick();
        check($sformatf("pow%0d_%0d valid@N+5", a, b), 32'(out_valid), 32'd1);
        check($sformatf("pow%0d_%0d busy@N+5", a, b), 32'(busy), 32'd0);
        check($sformatf("pow%0d_%0d result", a, b), 32'(out_result), 32'(exp_res));
        check($sformatf("pow%0d_%0d flag", a, b), 32'(out_flag), 32'd0);
        check($sformatf("pow%0d_%0d ready@N+5", a, b), 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vecs[1]  = '{3'd0, 16'h1234, 16'h1111, 16'h2345, 1'b0};
        vecs[2]  = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1};
        vecs[3]  = '{3'd1, 16'h000A, 16'h0003, 16'h0007, 1'b0};
        vecs[4]  = '{3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0};
        vecs[5]  = '{3'd3, 16'hF0F0, 16'h0F01, 16'hFFF1, 1'b0};
        vecs[6]  = '{3'd4, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0};
        vecs[7]  = '{3'd5, 16'h0001, 16'h0013, 16'h0008, 1'b0};
        vecs[8]  = '{3'd5, 16'h8001, 16'h000F, 16'h8000, 1'b0};
        vecs[9]  = '{3'd6, 16'd100,  16'd0,    16'h0000, 1'b1};
        vecs[10] = '{3'd6, 16'd100,  16'd7,    16'd14,   1'b0};
        vecs[11] = '{3'd6, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_result", 32'(out_result), 32'd0);
        check("reset out_flag", 32'(out_flag), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);

        // Single-cycle ops, one accept per cycle with the sink draining.
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b;
            tick();
            check($sformatf("vec%0d valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d result", i), 32'(out_result), 32'(vecs[i].res));
            check($sformatf("vec%0d flag", i), 32'(out_flag), 32'(vecs[i].flag));
        end
        in_valid = 1'b0;

        pow_check(16'd3, 16'd4, 16'd81);
        pow_check(16'd0, 16'd0, 16'd1);
        pow_check(16'd2, 16'd17, 16'd0);
        pow_check(16'd5, 16'h0021, 16'd5);
        pow_check(16'd2, 16'd15, 16'h8000);
        tick();

        // Back-to-back ADDs: one result per cycle.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_op = 3'd0; in_a = 16'(i * 16'h0100); in_b = 16'(i + 1);
            check($sformatf("b2b%0d in_ready", i), 32'(in_ready), 32'd1);
            tick();
            check($sformatf("b2b%0d valid", i), 32'(out_valid), 32'd1);
            check($sformatf("b2b%0d result", i), 32'(out_result), 32'(i * 16'h0100 + i + 1));
        end

        // Backpressure with changing inputs; only the release-cycle values count.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_op = (i == 1) ? 3'd4 : 3'd1; in_a = 16'(16'h7000 + i); in_b = 16'h00FF;
            #1;
            check($sformatf("hold%0d in_ready", i), 32'(in_ready), 32'd0);
            tick();
            check($sformatf("hold%0d valid", i), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d result", i), 32'(out_result), 32'h0304);
            check($sformatf("hold%0d flag", i), 32'(out_flag), 32'd0);
        end
        in_op = 3'd0; in_a = 16'h0100; in_b = 16'h0001;
        out_ready = 1'b1;
        #1;
        check("release in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("release valid", 32'(out_valid), 32'd1);
        check("release result", 32'(out_result), 32'h0101);
        tick();
        check("drain valid", 32'(out_valid), 32'd0);

        // Reset sampled at the second ITER edge aborts the POW.
        in_valid = 1'b1; in_op = 3'd7; in_a = 16'd3; in_b = 16'd4;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort valid", 32'(out_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = 3'd0; in_a = 16'd2; in_b = 16'd2;
        tick();
        in_valid = 1'b0;
        check("post-abort valid", 32'(out_valid), 32'd1);
        check("post-abort result", 32'(out_result), 32'd4);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("no-stale valid%0d", k), 32'(out_valid), 32'd0);
            check($sformatf("no-stale busy%0d", k), 32'(busy), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
